seg_scan: RTL and testbench

- Upstream driver for the 7-segment decoder in a 4-digit multiplexed display.
- Holds a 16-bit hex value plus per-digit decimal-point and blank masks.
- Scans one digit at a time: presents that digit's nibble on `digit` (fed straight into the decoder's 4-bit input) and drives the matching active-low anode.
- New values are double-buffered and only take effect at a frame boundary, so the display never tears mid-scan.

---
 rtl/seg_scan.sv | 127 ++++++++++++
 tb/tb_seg_scan.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Multiplexed 4-digit 7-segment scan driver: prescaled digit slots with an
// anode-off guard at the start of each slot and frame-synchronous double buffering.
module seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 100000,
  parameter int BLANK_CYC  = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic [3:0]                digit,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      dp_n,
  output logic                      pend,
  output logic                      frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [IW-1:0]             idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0]   sh_val, sh_val_nxt, pd_val, pd_val_nxt;
  logic [NUM_DIGITS-1:0]     sh_dp, sh_dp_nxt, pd_dp, pd_dp_nxt;
  logic [NUM_DIGITS-1:0]     sh_blank, sh_blank_nxt, pd_blank, pd_blank_nxt;
  logic                      pend_nxt;
  logic                      slot_end, frame_end;
  logic [3:0]                digit_nxt;
  logic [NUM_DIGITS-1:0]     an_nxt;
  logic                      dp_n_nxt;

  always_comb begin
    slot_end     = (cnt == SLOT_LAST);
    frame_end    = slot_end && (idx == IDX_LAST);
    cnt_nxt      = slot_end ? '0 : cnt + 1'b1;
    idx_nxt      = idx;
    state_nxt    = state;
    sh_val_nxt   = sh_val;
    sh_dp_nxt    = sh_dp;
    sh_blank_nxt = sh_blank;
    pd_val_nxt   = pd_val;
    pd_dp_nxt    = pd_dp;
    pd_blank_nxt = pd_blank;
    pend_nxt     = pend;

    if (slot_end) begin
      idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      state_nxt = (BLANK_CYC == 0) ? DRIVE : BLANK;
    end else if (state == BLANK && (BLANK_CYC == 0 || cnt == BLANK_LAST)) begin
      state_nxt = DRIVE;
    end

    if (load) begin
      pd_val_nxt   = data_in;
      pd_dp_nxt    = dp_in;
      pd_blank_nxt = blank_in;
      pend_nxt     = 1'b1;
    end

    // A load landing on the boundary itself bypasses the stale pending copy.
    if (frame_end) begin
      if (load) begin
        sh_val_nxt   = data_in;
        sh_dp_nxt    = dp_in;
        sh_blank_nxt = blank_in;
      end else if (pend) begin
        sh_val_nxt   = pd_val;
        sh_dp_nxt    = pd_dp;
        sh_blank_nxt = pd_blank;
      end
      pend_nxt = 1'b0;
    end

    // Outputs are derived from next-state so they register alongside it.
    digit_nxt = sh_val_nxt[{idx_nxt, 2'b00} +: 4];
    an_nxt    = '1;
    dp_n_nxt  = 1'b1;
    if (state_nxt == DRIVE) begin
      if (!sh_blank_nxt[idx_nxt]) an_nxt[idx_nxt] = 1'b0;
      dp_n_nxt = ~sh_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      pd_val     <= '0;
      pd_dp      <= '0;
      pd_blank   <= '0;
      pend       <= 1'b0;
      digit      <= 4'h0;
      an         <= '1;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      sh_val     <= sh_val_nxt;
      sh_dp      <= sh_dp_nxt;
      sh_blank   <= sh_blank_nxt;
      pd_val     <= pd_val_nxt;
      pd_dp      <= pd_dp_nxt;
      pd_blank   <= pd_blank_nxt;
      pend       <= pend_nxt;
      digit      <= digit_nxt;
      an         <= an_nxt;
      dp_n       <= dp_n_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: timeline-based reference model (slot = t/DIV, frame = t/(4*DIV))
// checked against a blanking instance and a BLANK_CYC=0 instance.
module tb_seg_scan;
  localparam int ND = 4;
  localparam int DV = 8;
  localparam int BC = 2;
  localparam int FR = ND * DV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  digit, an, digit0, an0;
  logic        dp_n, pend, frame_tick, dp_n0, pend0, frame_tick0;

  seg_scan #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .digit(digit), .an(an), .dp_n(dp_n), .pend(pend),
    .frame_tick(frame_tick));

  seg_scan #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .digit(digit0), .an(an0), .dp_n(dp_n0), .pend(pend0),
    .frame_tick(frame_tick0));

  always #5 clk = ~clk;

  int          t;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_bl, p_dp, p_bl;
  bit          m_pf;
  logic [3:0]  e_digit, e_an, e_an0;
  logic        e_dp_n, e_pend, e_ft;
  logic [10:0] e_all;
  int          checks = 0;
  int          failures = 0;

  // Advance one clock: update the model from the inputs seen at this edge,
  // then compute what every output should show during the new cycle.
  task automatic tick();
    int idx, pos;
    @(posedge clk);
    if (!rst) begin
      t = 0; m_val = '0; m_dp = '0; m_bl = '0;
      p_val = '0; p_dp = '0; p_bl = '0; m_pf = 0;
    end else begin
      if (t % FR == FR - 1) begin
        if (load) {m_val, m_dp, m_bl} = {data_in, dp_in, blank_in};
        else if (m_pf) {m_val, m_dp, m_bl} = {p_val, p_dp, p_bl};
        m_pf = 0;
      end else if (load) begin
        m_pf = 1;
      end
      if (load) {p_val, p_dp, p_bl} = {data_in, dp_in, blank_in};
      t++;
    end
    #1;
    idx = (t / DV) % ND;
    pos = t % DV;
    e_digit = 4'(m_val >> (4 * idx));
    e_an = 4'hF;
    if (pos >= BC && !m_bl[idx]) e_an[idx] = 1'b0;
    e_an0 = 4'hF;
    if (!m_bl[idx]) e_an0[idx] = 1'b0;
    e_dp_n = (pos >= BC) ? ~m_dp[idx] : 1'b1;
    e_pend = m_pf;
    e_ft = (t > 0) && (t % FR == 0);
    e_all = {e_digit, e_an, e_dp_n, e_pend, e_ft};
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    data_in = v; dp_in = d; blank_in = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({digit, an, dp_n, pend, frame_tick} !== 11'b0000_1111_1_0_0) begin
      failures++;
      $display("FAIL reset: got digit=%h an=%b dp_n=%b pend=%b ft=%b, want 0 1111 1 0 0",
               digit, an, dp_n, pend, frame_tick);
    end
    checks++;
    if (an0 !== 4'hF) begin
      failures++;
      $display("FAIL reset_an0: got %b want 1111", an0);
    end
    rst = 1'b1;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({digit, an, dp_n, pend, frame_tick} !== e_all) begin
        failures++;
        $display("FAIL scan t=%0d: got %h/%b/%b/%b/%b want %b", t, digit, an, dp_n, pend, frame_tick, e_all);
      end
      checks++;
      if (frame_tick !== (t == 32)) begin
        failures++;
        $display("FAIL scan_tick t=%0d: got %b want %b", t, frame_tick, t == 32);
      end
    end
  endtask

  task automatic test_load();
    do_load(16'hA3C5, 4'b0100, 4'b0000);
    checks++;
    if (pend !== 1'b1 || digit !== 4'h0) begin
      failures++;
      $display("FAIL load_pend: got pend=%b digit=%h want pend=1 digit=0", pend, digit);
    end
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if ({digit, an, dp_n, pend, frame_tick} !== e_all) begin
        failures++;
        $display("FAIL load t=%0d: got %h/%b/%b/%b/%b want %b", t, digit, an, dp_n, pend, frame_tick, e_all);
      end
    end
  endtask

  task automatic test_last_write();
    do_load(16'h1111, 4'b0000, 4'b0000);
    tick(); tick();
    do_load(16'h2222, 4'b0000, 4'b0000);
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if ({digit, an, dp_n, pend, frame_tick} !== e_all || digit === 4'h1) begin
        failures++;
        $display("FAIL last_write t=%0d: got digit=%h an=%b pend=%b want %b", t, digit, an, pend, e_all);
      end
    end
  endtask

  task automatic test_load_on_frame_end();
    for (int i = 0; i < FR && (t % FR) != FR - 1; i++) tick();
    do_load(16'h00F0, 4'b0000, 4'b0000);
    checks++;
    if (digit !== 4'h0 || pend !== 1'b0 || frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL frame_end_load: got digit=%h pend=%b ft=%b want 0 0 1", digit, pend, frame_tick);
    end
    for (int i = 0; i < FR; i++) begin
      tick();
      checks++;
      if ({digit, an, dp_n, pend, frame_tick} !== e_all) begin
        failures++;
        $display("FAIL frame_end_load t=%0d: got %h/%b/%b/%b/%b want %b", t, digit, an, dp_n, pend, frame_tick, e_all);
      end
    end
  endtask

  task automatic test_blank();
    do_load(16'($urandom), 4'($urandom), 4'b1001);
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if ({digit, an, dp_n, pend, frame_tick} !== e_all || (e_ft === 1'b0 && !m_pf && (an[0] === 1'b0 || an[3] === 1'b0))) begin
        failures++;
        $display("FAIL blank t=%0d: got digit=%h an=%b want %b", t, digit, an, e_all);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_load(16'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < FR && (t % FR) != 2 * DV + 3; i++) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({digit, an, dp_n, pend, frame_tick} !== 11'b0000_1111_1_0_0) begin
      failures++;
      $display("FAIL reset_mid: got digit=%h an=%b dp_n=%b pend=%b want 0 1111 1 0", digit, an, dp_n, pend);
    end
    rst = 1'b1;
    for (int i = 0; i < FR + 4; i++) begin
      tick();
      checks++;
      if ({digit, an, dp_n, pend, frame_tick} !== e_all || digit !== 4'h0) begin
        failures++;
        $display("FAIL reset_mid t=%0d: got %h/%b/%b/%b/%b want %b", t, digit, an, dp_n, pend, frame_tick, e_all);
      end
    end
  endtask

  task automatic test_no_blank();
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if (t > 0 && an0 !== e_an0) begin
        failures++;
        $display("FAIL no_blank t=%0d: got an0=%b want %b", t, an0, e_an0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      data_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
      load = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if ({digit, an, dp_n, pend, frame_tick} !== e_all || (t > 0 && an0 !== e_an0)) begin
        failures++;
        $display("FAIL random t=%0d: got %h/%b/%b/%b/%b an0=%b want %b an0=%b",
                 t, digit, an, dp_n, pend, frame_tick, an0, e_all, e_an0);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_last_write();
    test_load_on_frame_end();
    test_blank();
    test_reset_mid();
    test_no_blank();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
